fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the team's synchronous FIFO between `NUM_REQ` producers. It sits directly in front of the FIFO: it drives `wr_en`/`data_in` and watches `full`. It returns a one-hot grant to each producer using a valid/ready-style handshake. An optional burst-lock mode lets a winner keep the port for several consecutive beats.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers; 2..8.
- `DATA_WIDTH`, 16: word width; matches the FIFO.
- `BURST_LEN`, 4: maximum consecutive beats per owner in burst mode; 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  `NUM_REQ`  producer i has a word pending.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`  producer i's word in slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt`  out  `NUM_REQ`  one-hot, combinational; `req[i] & gnt[i]` at a rising edge means the word is accepted.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write enable, combinational.
- `fifo_data_in`  out  `DATA_WIDTH`  FIFO write data; equals the granted slice, else 0.
- `owner`  out  `$clog2(NUM_REQ)`  registered index of the current or last burst owner; status only.

## Operation
- Transfer condition: `fifo_wr_en = |gnt`. `gnt` is nonzero only when `|req & !fifo_full & !rst`.
- At most one `gnt` bit is high. `gnt[i]` implies `req[i]`.
- Round-robin pointer `rr_ptr` marks the highest-priority index. Search order is `rr_ptr, rr_ptr+1, … mod NUM_REQ`.
- State machine (`arb_state_e`):
  - **ARB_IDLE**: the winner is chosen by round-robin from `rr_ptr`.
    - On a transfer without burst mode: `rr_ptr <= winner+1` (mod `NUM_REQ`); stay in IDLE.
    - On a transfer with burst mode: `owner <= winner`, `beat_cnt <= 1`, go to ARB_BURST.
  - **ARB_BURST**: if `req[owner]` is high, `owner` wins unconditionally.
    - On a transfer, `beat_cnt` increments.
    - When the transfer makes `beat_cnt == BURST_LEN`: `rr_ptr <= owner+1`, go to IDLE.
    - If `req[owner]` is low: round-robin among the others starting at `owner+1`; `rr_ptr <= owner+1`; go to IDLE. A transfer that cycle is a normal IDLE-style grant, not a new burst.
- `fifo_full` high: no grant. `rr_ptr`, `beat_cnt`, `owner` and the state all hold, so a burst resumes after full clears.
- `rr_ptr` wraps from `NUM_REQ-1` to 0. `beat_cnt` is `$clog2(BURST_LEN+1)` bits wide and never exceeds `BURST_LEN`.

## Timing
- Latency from request to grant is 0 cycles (combinational path `req`/`fifo_full` → `gnt`/`fifo_wr_en`). The FIFO captures the word at the same edge.
- Producers hold `req[i]` and the data slice stable until they see `gnt[i]`. Producers must not drop `req` combinationally in response to `gnt`.
- Reset values while `rst` is high: `gnt=0`, `fifo_wr_en=0`, `fifo_data_in=0`.
- Registered state after the reset edge: `rr_ptr=0`, `owner=0`, `beat_cnt=0`, state ARB_IDLE.
- Reset asserted mid-burst aborts the burst. No write is issued in the reset cycle.
- All requesters idle: all outputs are 0 and the state holds.

## Configuration
- Macro `FIFO_ARB_BURST_EN`.
- Defined: ARB_BURST exists; behaviour is as above with `BURST_LEN`.
- Undefined: the state machine never leaves ARB_IDLE; grants rotate every beat; `beat_cnt` logic is removed; `owner` tracks the last winner.

## Structure
- `shared_pkg` additions:
  - `typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e`
  - `localparam ARB_MAX_REQ = 8`
- Sub-module `fifo_rr_picker`: combinational rotate-priority encoder with inputs `req` and `start_idx`, outputs one-hot `pick` and `pick_idx`. It is instantiated once; the burst override muxes around it.

## Test plan
- Reset then `req=4'b1111`, `fifo_full=0`, burst off.
  - Required: `gnt` sequence `0001,0010,0100,1000,0001`; `fifo_data_in` matches each slice.
- `req=4'b1010` constant, burst off.
  - Required: `gnt` alternates `0010,1000`; `rr_ptr` wraps 3→0 and then picks index 1.
- Burst on, `BURST_LEN=4`, `req=4'b0011`.
  - Required: `gnt=0001` for 4 beats, then `0010` for 4 beats, then `0001` again.
- Burst on: owner 2 gets 2 beats, then `fifo_full=1` for 3 cycles, then 0.
  - Required: `gnt=0` and `fifo_wr_en=0` during full; afterwards 2 more beats to owner 2, then rotation to 3.
- Burst on: owner 1 drops `req` after beat 1 while `req[3]=1`.
  - Required: `gnt=1000` in the same cycle; state returns to IDLE; `rr_ptr=2`.
- `rst=1` for one cycle mid-burst, with `req=4'b1111` held.
  - Required: `gnt=0` in the reset cycle; the next grant is `0001`.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Holds the arbiter state encoding and size limits.
package shared_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_e;

    localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/fifo_rr_picker.sv
// Rotate-priority encoder: first set req bit at or after start_idx.
// Purely combinational; emits one-hot pick and its index.
module fifo_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start_idx,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      pick_idx
);

    logic found;
    int   idx;

    // Walk indices in wrap-around order from start_idx, keep first hit.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start_idx) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to let a winner hold the port for BURST_LEN beats.
module fifo_wr_arbiter
    import shared_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("fifo_wr_arbiter: NUM_REQ out of range");
    end
    if (BURST_LEN < 2 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("fifo_wr_arbiter: BURST_LEN out of range");
    end

    arb_state_e state_q, state_d;

    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      start_idx;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      win_idx;
    logic [NUM_REQ-1:0] pick;
    logic               can_gnt;
    logic               hold;
    logic               xfer;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        if (i == IW'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

`ifdef FIFO_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);

    logic [CW-1:0] beat_q, beat_d;

    assign hold      = (state_q == ARB_BURST) && req[owner_q];
    assign start_idx = (state_q == ARB_BURST) ? wrap_inc(owner_q) : rr_q;
`else
    assign hold      = 1'b0;
    assign start_idx = rr_q;
`endif

    fifo_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req       (req),
        .start_idx (start_idx),
        .pick      (pick),
        .pick_idx  (pick_idx)
    );

    assign can_gnt    = !rst && !fifo_full;
    assign win_idx    = hold ? owner_q : pick_idx;
    assign fifo_wr_en = |gnt;
    assign xfer       = fifo_wr_en;
    assign owner      = owner_q;

    // Grant: burst owner overrides the picker; full or reset blocks all.
    always_comb begin
        gnt = '0;
        if (can_gnt) begin
            if (hold) begin
                gnt[owner_q] = 1'b1;
            end else begin
                gnt = pick;
            end
        end
    end

    // Steer the granted producer's word to the FIFO, zero otherwise.
    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state: pointer rotation, burst ownership and beat counting.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
`ifdef FIFO_ARB_BURST_EN
        beat_d  = beat_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (xfer) begin
                    owner_d = win_idx;
`ifdef FIFO_ARB_BURST_EN
                    beat_d  = CW'(1);
                    state_d = ARB_BURST;
`else
                    rr_d    = wrap_inc(win_idx);
`endif
                end
            end
            ARB_BURST: begin
`ifdef FIFO_ARB_BURST_EN
                if (hold) begin
                    if (xfer) begin
                        beat_d = beat_q + 1'b1;
                        if (beat_q + 1'b1 == CW'(BURST_LEN)) begin
                            rr_d    = wrap_inc(owner_q);
                            state_d = ARB_IDLE;
                        end
                    end
                end else if (!fifo_full) begin
                    rr_d    = wrap_inc(owner_q);
                    state_d = ARB_IDLE;
                end
`else
                state_d = ARB_IDLE;
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State register with synchronous reset; reset aborts any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
`ifdef FIFO_ARB_BURST_EN
            beat_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
`ifdef FIFO_ARB_BURST_EN
            beat_q  <= beat_d;
`endif
        end
    end

endmodule
